// File: rtl/mult_operand_sequencer.sv
// mult_operand_sequencer
//   Feeds operand pairs to an 8x8 sequential multiplier (mult8x8) and collects
//   its products. Pairs enter through a small FIFO. Each pair is presented on
//   mult_dataa/mult_datab, start is pulsed, and the rising edge of done is
//   awaited. The product is then offered on a result port with backpressure.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high. in_ready/res_valid do not depend combinationally on
//   in_valid/res_ready. res_valid and res_data hold until accepted.
//
//   Optional build macro MULT_TIMEOUT_EN adds an abort counter in WAIT. When
//   TIMEOUT_CYCLES WAIT cycles pass without a done edge, the result is 16'hFFFF
//   and res_timeout is set.
//
// Ports:
//   clk, aclr_n            clock (rising edge), async active-low reset
//   in_valid/in_ready      operand pair handshake; in_ready = !full
//   in_a, in_b             multiplicand / multiplier
//   mult_dataa/datab       operands to mult8x8, stable from pop until capture
//   mult_start             one-cycle start pulse to mult8x8
//   mult_done              mult8x8 done_flag
//   mult_product           mult8x8 product8x8_out
//   res_valid/res_ready    result handshake
//   res_data               captured product
//   busy                   FSM not in IDLE
//   fifo_level             current FIFO occupancy
//   res_timeout            (MULT_TIMEOUT_EN only) result came from an abort
module mult_operand_sequencer #(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic                     clk,
   input  logic                     aclr_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [7:0]               in_a,
   input  logic [7:0]               in_b,
   output logic [7:0]               mult_dataa,
   output logic [7:0]               mult_datab,
   output logic                     mult_start,
   input  logic                     mult_done,
   input  logic [15:0]              mult_product,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [15:0]              res_data,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_level
`ifdef MULT_TIMEOUT_EN
   ,
   output logic                     res_timeout
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   // Reject configurations the pointer/counter arithmetic cannot support.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
       TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
      $error("mult_operand_sequencer: unsupported DEPTH/TIMEOUT_CYCLES");
   end

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [7:0]      r_mem_a [DEPTH];
   logic [7:0]      r_mem_b [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [LW-1:0]   r_level;
   logic [7:0]      r_dataa;
   logic [7:0]      r_datab;
   logic [15:0]     r_res_data;
   logic            r_done_d;
   logic            w_push;
   logic            w_pop;
   logic            w_done_edge;
   logic            w_capture;
`ifdef MULT_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0]      r_tmo_cnt;
   logic            r_res_timeout;
   logic            w_timeout;
`endif

   assign w_push      = in_valid && in_ready;
   assign w_pop       = (r_state == S_IDLE) && (r_level != '0);
   // done_d is sampled every cycle, so in the first WAIT cycle it holds the
   // value seen during START; a done already high at START is not an edge.
   assign w_done_edge = mult_done && !r_done_d;

   // ---------------- FIFO ----------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_a[r_wr_ptr] <= in_a;
         r_mem_b[r_wr_ptr] <= in_b;
      end
   end

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) r_state <= S_IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
`ifdef MULT_TIMEOUT_EN
      w_timeout    = 1'b0;
`endif
      case (r_state)
         S_IDLE:  if (r_level != '0) w_next_state = S_START;
         S_START: w_next_state = S_WAIT;
         S_WAIT: begin
            if (w_done_edge) begin
               w_capture    = 1'b1;
               w_next_state = S_OUT;
            end
`ifdef MULT_TIMEOUT_EN
            else if (r_tmo_cnt == TMO_LAST) begin
               w_timeout    = 1'b1;
               w_next_state = S_OUT;
            end
`endif
         end
         S_OUT:   if (res_ready) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         r_dataa    <= '0;
         r_datab    <= '0;
         r_res_data <= '0;
         r_done_d   <= 1'b0;
      end else begin
         r_done_d <= mult_done;
         // Operands only change on a pop, so they hold through START and WAIT.
         if (w_pop) begin
            r_dataa <= r_mem_a[r_rd_ptr];
            r_datab <= r_mem_b[r_rd_ptr];
         end
         if (w_capture) r_res_data <= mult_product;
`ifdef MULT_TIMEOUT_EN
         else if (w_timeout) r_res_data <= 16'hFFFF;
`endif
      end
   end

`ifdef MULT_TIMEOUT_EN
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         r_tmo_cnt     <= '0;
         r_res_timeout <= 1'b0;
      end else begin
         if (r_state == S_START)     r_tmo_cnt <= '0;
         else if (r_state == S_WAIT) r_tmo_cnt <= r_tmo_cnt + 8'd1;
         if (w_capture)      r_res_timeout <= 1'b0;
         else if (w_timeout) r_res_timeout <= 1'b1;
      end
   end
   assign res_timeout = r_res_timeout;
`endif

   assign in_ready   = (r_level != FULL_LVL);
   assign mult_dataa = r_dataa;
   assign mult_datab = r_datab;
   assign mult_start = (r_state == S_START);
   assign res_valid  = (r_state == S_OUT);
   assign res_data   = r_res_data;
   assign busy       = (r_state != S_IDLE);
   assign fifo_level = r_level;

endmodule

// File: doc/mult_operand_sequencer.md
Name: mult_operand_sequencer

Overview:
- Upstream feeder and downstream collector for the 8x8 sequential multiplier (mult8x8).
- Accepts operand pairs over a valid/ready interface and buffers them in a small FIFO.
- Presents each pair stable on dataa/datab, pulses start, and waits for the multiplier's done_flag rising edge.
- Captures product8x8_out and offers it on a valid/ready result port with backpressure, so jobs can be streamed without software polling.

Parameters:
DEPTH, 4, operand FIFO entries; power of 2, minimum 2
TIMEOUT_CYCLES, 32, cycles allowed in WAIT before abort; used only with MULT_TIMEOUT_EN

Ports:
clk  in  1  system clock, rising edge
aclr_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair offered
in_ready  out  1  FIFO can accept; equals !full
in_a  in  8  multiplicand
in_b  in  8  multiplier
mult_dataa  out  8  to mult8x8 dataa; stable from START through capture
mult_datab  out  8  to mult8x8 datab
mult_start  out  1  one-cycle start pulse to mult8x8
mult_done  in  1  mult8x8 done_flag
mult_product  in  16  mult8x8 product8x8_out
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  16  captured product
busy  out  1  high in any state other than IDLE
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
res_timeout  out  1  present only with MULT_TIMEOUT_EN

Behaviour:
- Reset (aclr_n low, asynchronous): FSM to IDLE, FIFO empty, fifo_level 0, in_ready 1, mult_dataa/mult_datab 0, mult_start 0, res_valid 0, res_data 0, busy 0, done-edge register 0.
- Reset mid-operation discards all buffered and in-flight jobs; no result is emitted.
- FIFO push: in_valid & in_ready.
- FIFO pop: FSM in IDLE and FIFO non-empty.
- Push and pop in the same cycle: both occur, level unchanged.
- Full: in_ready = 0; offered data is ignored.
- Pointers wrap modulo DEPTH. The level counter distinguishes full from empty.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into mult_dataa/mult_datab, go to START. Otherwise stay.
  - START: mult_start = 1 for exactly this cycle; go to WAIT.
  - WAIT: mult_start = 0. Register done_d <= mult_done every cycle.
    - On mult_done & !done_d (rising edge, first detected the cycle after START): res_data <= mult_product, go to OUT.
    - A done_flag already high at START is not an edge; wait for it to fall and rise again.
  - OUT: res_valid = 1, res_data held. On res_ready go to IDLE. res_valid drops the following cycle.
- Operands stay constant from the pop until leaving WAIT.
- Minimum latency:
  - Push into an empty idle block -> FIFO non-empty next cycle -> IDLE pop -> START one cycle later. Push to mult_start is 2 cycles.
  - Done edge to res_valid is 1 cycle.
  - OUT to the next START is 2 cycles: OUT -> IDLE -> START.
- Arithmetic: none internally; res_data is the unmodified 16-bit product.
- busy = (state != IDLE).

Optional Feature:
MULT_TIMEOUT_EN
- Defined:
  - 8-bit cycle counter cleared on START, incremented in WAIT.
  - If it reaches TIMEOUT_CYCLES with no done edge: res_data <= 16'hFFFF, res_timeout <= 1, go to OUT.
  - res_timeout is cleared when a normal capture occurs and on reset.
  - res_timeout is valid alongside res_valid.
- Undefined: no counter and no res_timeout port; WAIT waits indefinitely.

Test Plan:
- Single job: push a=0x0F, b=0x11 with a mult8x8 instance attached -> one mult_start pulse, then res_valid with res_data=0x00FF; res_ready=1 returns FSM to IDLE, busy=0.
- Max operands and back-to-back: push (0xFF,0xFF) then (0x80,0x02) on consecutive cycles -> results 0xFE01 then 0x0100 in order. mult_dataa/mult_datab stable throughout each WAIT. Exactly two start pulses.
- FIFO full (DEPTH=4): bench multiplier model holds done low, push 6 pairs -> first pair moves to the operand registers. in_ready drops after 5 accepted pushes, fifo_level=4, 6th pair ignored. Release done edges -> 5 results in push order.
- Backpressure: hold res_ready=0 for 10 cycles -> res_valid stays 1, res_data constant, no further mult_start. Release -> next job starts 2 cycles later.
- Stale done: model holds done=1 at START, drops it 2 cycles later, raises it 3 cycles after that -> capture only on the second rising edge.
- Reset mid-job: assert aclr_n=0 during WAIT with 3 entries buffered -> all outputs at reset values immediately, fifo_level=0, no res_valid after release. With MULT_TIMEOUT_EN and done never rising -> res_valid after TIMEOUT_CYCLES=32 WAIT cycles with res_data=0xFFFF, res_timeout=1.
